// File: rtl/fft_pkg.sv
// Shared FFT types and the elaboration-time quarter-wave twiddle helper.
package fft_pkg;

  typedef enum logic [0:0] {TW_IDLE = 1'b0, TW_RUN = 1'b1} tw_state_e;

  typedef enum logic [1:0] {QUAD_0 = 2'd0, QUAD_1 = 2'd1, QUAD_2 = 2'd2, QUAD_3 = 2'd3} quad_e;

  localparam real TW_PI = 3.14159265358979323846;

  // Quarter-wave entry: trunc_toward_zero(2^(w-2) * cos|sin(2*pi*r/n)).
  function automatic int twiddle_q(input int r, input int n, input int w, input bit is_sin);
    real ang;
    real mag;
    ang = 2.0 * TW_PI * real'(r) / real'(n);
    mag = is_sin ? $sin(ang) : $cos(ang);
    return $rtoi(mag * real'(1 << (w - 2)));
  endfunction

endpackage

// File: rtl/twiddle_qrom.sv
// Registered dual-output quarter-wave ROM: r in, c[r] and s[r] out one cycle later.
module twiddle_qrom
  import fft_pkg::*;
#(
  parameter int unsigned N_POINTS = 32,
  parameter int unsigned W_WIDTH  = 9,
  parameter int unsigned R_W      = $clog2(N_POINTS) - 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [R_W-1:0]     r_i,
  output logic [W_WIDTH-1:0] cos_o,
  output logic [W_WIDTH-1:0] sin_o
);

  localparam int unsigned DEPTH = N_POINTS / 4;

  logic [W_WIDTH-1:0] cos_tab [DEPTH];
  logic [W_WIDTH-1:0] sin_tab [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_tab
    assign cos_tab[i] = W_WIDTH'(twiddle_q(i, N_POINTS, W_WIDTH, 1'b0));
    assign sin_tab[i] = W_WIDTH'(twiddle_q(i, N_POINTS, W_WIDTH, 1'b1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cos_o <= '0;
      sin_o <= '0;
    end else begin
      cos_o <= cos_tab[r_i];
      sin_o <= sin_tab[r_i];
    end
  end

endmodule

// File: rtl/twiddle_gen.sv
// Pipelined stage-strided twiddle generator (quarter-wave ROM + quadrant unfold).
// Define TWIDDLE_IFFT_EN to honour the inv input (conjugate output for inverse FFT).
module twiddle_gen
  import fft_pkg::*;
#(
  parameter int unsigned N_POINTS = 32,
  parameter int unsigned W_WIDTH  = 9,
  parameter int unsigned STG_W    = $clog2($clog2(N_POINTS))
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [STG_W-1:0]            stage,
  input  logic                        advance,
  input  logic                        inv,
  output logic                        tw_valid,
  output logic signed [W_WIDTH-1:0]   tw_re,
  output logic signed [W_WIDTH-1:0]   tw_im,
  output logic [$clog2(N_POINTS)-1:0] tw_idx,
  output logic                        tw_last
);

  localparam int unsigned IDX_W = $clog2(N_POINTS);
  localparam int unsigned R_W   = IDX_W - 2;
  localparam int unsigned S_MAX = IDX_W - 2;

  localparam logic [0:0] IDLE = TW_IDLE;
  localparam logic [0:0] RUN  = TW_RUN;

  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] n_q, n_d;
  logic [STG_W-1:0] s_q, s_d;

  logic             p1_vld_q, p1_vld_d;
  logic [R_W-1:0]   p1_r_q, p1_r_d;
  quad_e            p1_quad_q, p1_quad_d;
  logic             p1_last_q, p1_last_d;
  logic [IDX_W-1:0] p1_idx_q, p1_idx_d;
  logic             p1_inv_q, p1_inv_d;

  logic             p2_vld_q, p2_vld_d;
  quad_e            p2_quad_q, p2_quad_d;
  logic             p2_last_q, p2_last_d;
  logic [IDX_W-1:0] p2_idx_q, p2_idx_d;
  logic             p2_inv_q, p2_inv_d;

  logic [IDX_W-1:0] k_c;
  logic [IDX_W-1:0] n_max_c;

`ifndef TWIDDLE_IFFT_EN
  logic unused_inv;
  assign unused_inv = inv;
`endif

  // Sweep control and P1/P2 next-state.
  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    s_d       = s_q;
    p1_vld_d  = 1'b0;
    p1_r_d    = p1_r_q;
    p1_quad_d = p1_quad_q;
    p1_last_d = p1_last_q;
    p1_idx_d  = p1_idx_q;
    p1_inv_d  = p1_inv_q;
    k_c       = n_q << s_q;
    n_max_c   = IDX_W'((N_POINTS >> (32'(s_q) + 32'd1)) - 32'd1);

    if (start) begin
      state_d = RUN;
      n_d     = '0;
      s_d     = (32'(stage) > S_MAX) ? STG_W'(S_MAX) : stage;
    end else if (state_q == RUN && advance) begin
      p1_vld_d  = 1'b1;
      p1_r_d    = k_c[R_W-1:0];
      p1_quad_d = quad_e'(k_c[IDX_W-1 -: 2]);
      p1_last_d = (n_q == n_max_c);
      p1_idx_d  = k_c;
`ifdef TWIDDLE_IFFT_EN
      p1_inv_d  = inv;
`else
      p1_inv_d  = 1'b0;
`endif
      n_d       = (n_q == n_max_c) ? '0 : n_q + 1'b1;
    end

    p2_vld_d  = p1_vld_q;
    p2_quad_d = p1_quad_q;
    p2_last_d = p1_vld_q & p1_last_q;
    p2_idx_d  = p1_idx_q;
    p2_inv_d  = p1_inv_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      n_q       <= '0;
      s_q       <= '0;
      p1_vld_q  <= 1'b0;
      p1_r_q    <= '0;
      p1_quad_q <= QUAD_0;
      p1_last_q <= 1'b0;
      p1_idx_q  <= '0;
      p1_inv_q  <= 1'b0;
      p2_vld_q  <= 1'b0;
      p2_quad_q <= QUAD_0;
      p2_last_q <= 1'b0;
      p2_idx_q  <= '0;
      p2_inv_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      s_q       <= s_d;
      p1_vld_q  <= p1_vld_d;
      p1_r_q    <= p1_r_d;
      p1_quad_q <= p1_quad_d;
      p1_last_q <= p1_last_d;
      p1_idx_q  <= p1_idx_d;
      p1_inv_q  <= p1_inv_d;
      p2_vld_q  <= p2_vld_d;
      p2_quad_q <= p2_quad_d;
      p2_last_q <= p2_last_d;
      p2_idx_q  <= p2_idx_d;
      p2_inv_q  <= p2_inv_d;
    end
  end

  logic [W_WIDTH-1:0] rom_cos, rom_sin;

  twiddle_qrom #(
    .N_POINTS (N_POINTS),
    .W_WIDTH  (W_WIDTH),
    .R_W      (R_W)
  ) u_qrom (
    .clk   (clk),
    .rst   (rst),
    .r_i   (p1_r_q),
    .cos_o (rom_cos),
    .sin_o (rom_sin)
  );

  logic signed [W_WIDTH-1:0] cos_v, sin_v;
  assign cos_v = signed'(rom_cos);
  assign sin_v = signed'(rom_sin);

  // Quadrant unfold; magnitudes never exceed 2^(W-2) so negation cannot overflow.
  always_comb begin
    tw_re = '0;
    tw_im = '0;
    case (p2_quad_q)
      QUAD_0: begin tw_re =  cos_v; tw_im = -sin_v; end
      QUAD_1: begin tw_re = -sin_v; tw_im = -cos_v; end
      QUAD_2: begin tw_re = -cos_v; tw_im =  sin_v; end
      QUAD_3: begin tw_re =  sin_v; tw_im =  cos_v; end
    endcase
    if (p2_inv_q) tw_im = -tw_im;
  end

  assign tw_valid = p2_vld_q;
  assign tw_idx   = p2_idx_q;
  assign tw_last  = p2_last_q;

endmodule

// File: tb/tb_twiddle_gen.sv
// Vector table + scoreboard bench for twiddle_gen at N=32, W=9.
`timescale 1ns/1ps
module tb_twiddle_gen;

  localparam int N     = 32;
  localparam int W     = 9;
  localparam int STG_W = 3;

  logic                clk = 1'b0;
  logic                rst, start, advance, inv;
  logic [STG_W-1:0]    stage;
  logic                tw_valid, tw_last;
  logic signed [W-1:0] tw_re, tw_im;
  logic [4:0]          tw_idx;

  always #5 clk = ~clk;

  twiddle_gen #(.N_POINTS(N), .W_WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stage    (stage),
    .advance  (advance),
    .inv      (inv),
    .tw_valid (tw_valid),
    .tw_re    (tw_re),
    .tw_im    (tw_im),
    .tw_idx   (tw_idx),
    .tw_last  (tw_last)
  );

  typedef struct {
    bit rst;
    bit st;
    int sg;
    bit adv;
    bit iv;
    int exp_k;
    bit exp_last;
  } vec_t;

  typedef struct {
    int due;
    int k;
    int re;
    int im;
    bit last;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  int c_tab[8] = '{128, 125, 118, 106, 90, 71, 48, 24};
  int s_tab[8] = '{0, 24, 48, 71, 90, 106, 118, 125};

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mkv(bit r, bit st, int sg, bit adv, bit iv, int k, bit last);
    vec_t v;
    v.rst = r; v.st = st; v.sg = sg; v.adv = adv; v.iv = iv; v.exp_k = k; v.exp_last = last;
    return v;
  endfunction

  function automatic void add(bit r, bit st, int sg, bit adv, bit iv, int k, bit last);
    vecs.push_back(mkv(r, st, sg, adv, iv, k, last));
  endfunction

  function automatic void idle(int n);
    for (int i = 0; i < n; i++) add(0, 0, 0, 0, 0, -1, 0);
  endfunction

  function automatic exp_t mk_exp(int k, bit last, bit iv, int due);
    exp_t e;
    int q, r;
    q = k / 8;
    r = k % 8;
    case (q)
      0:       begin e.re =  c_tab[r]; e.im = -s_tab[r]; end
      1:       begin e.re = -s_tab[r]; e.im = -c_tab[r]; end
      2:       begin e.re = -c_tab[r]; e.im =  s_tab[r]; end
      default: begin e.re =  s_tab[r]; e.im =  c_tab[r]; end
    endcase
`ifdef TWIDDLE_IFFT_EN
    if (iv) e.im = -e.im;
`endif
    e.k = k; e.last = last; e.due = due;
    return e;
  endfunction

  task automatic check_out();
    exp_t e;
    if (tw_valid) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", int'(tw_valid), 0);
      end else begin
        e = sb.pop_front();
        chk("latency", cyc, e.due);
        chk("tw_idx", int'(tw_idx), e.k);
        chk("tw_re", int'(tw_re), e.re);
        chk("tw_im", int'(tw_im), e.im);
        chk("tw_last", int'(tw_last), int'(e.last));
      end
    end else if (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      chk("missing_valid", int'(tw_valid), 1);
    end
  endtask

  task automatic apply(input vec_t v);
    rst     = v.rst;
    start   = v.st;
    stage   = STG_W'(v.sg);
    advance = v.adv;
    inv     = v.iv;
    if (v.rst) sb.delete();
    if (v.exp_k >= 0) sb.push_back(mk_exp(v.exp_k, v.exp_last, v.iv, cyc + 2));
    @(posedge clk);
    #1;
    cyc++;
    if (v.rst) begin
      chk("rst_valid", int'(tw_valid), 0);
      chk("rst_re", int'(tw_re), 0);
      chk("rst_im", int'(tw_im), 0);
      chk("rst_idx", int'(tw_idx), 0);
      chk("rst_last", int'(tw_last), 0);
    end
    check_out();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; stage = '0; advance = 1'b0; inv = 1'b0;

    idle(1);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 1, 0, -1, 0);        // advance in IDLE
    add(0, 1, 0, 1, 0, -1, 0);                                    // start wins over advance
    for (int i = 0; i < 16; i++) add(0, 0, 0, 1, 0, i, i == 15);
    idle(3);
    add(0, 1, 1, 0, 0, -1, 0);
    for (int i = 0; i < 9; i++) add(0, 0, 0, 1, 0, 2 * (i % 8), (i % 8) == 7);
    idle(3);
    add(0, 1, 7, 0, 0, -1, 0);                                    // clamped to s=3
    for (int i = 0; i < 5; i++) add(0, 0, 0, 1, 0, 8 * (i % 2), (i % 2) == 1);
    idle(3);
    add(0, 1, 0, 0, 0, -1, 0);
    add(0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, -1, 0);
    add(0, 0, 0, 1, 0, 1, 0);
    add(0, 0, 0, 1, 0, 2, 0);
    add(0, 0, 0, 0, 0, -1, 0);
    idle(3);
    add(0, 1, 0, 0, 0, -1, 0);
    add(0, 0, 0, 1, 1, 0, 0);
    add(0, 0, 0, 1, 1, 1, 0);
    add(0, 0, 0, 1, 0, 2, 0);
    add(0, 0, 0, 1, 1, 3, 0);
    idle(3);
    add(0, 1, 0, 0, 0, -1, 0);                                    // restart mid-sweep, no flush
    add(0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 1, 0);
    add(0, 1, 1, 1, 0, -1, 0);
    add(0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 2, 0);
    idle(3);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", int'(tw_valid), 0);
    chk("reset_re", int'(tw_re), 0);
    chk("reset_im", int'(tw_im), 0);
    chk("reset_idx", int'(tw_idx), 0);
    chk("reset_last", int'(tw_last), 0);

    foreach (vecs[i]) apply(vecs[i]);
    chk("sweep_drained", sb.size(), 0);

    // Reset with two twiddles in flight: both must vanish and the FSM returns to IDLE.
    apply(mkv(0, 1, 0, 0, 0, -1, 0));
    apply(mkv(0, 0, 0, 1, 0, 0, 0));
    apply(mkv(0, 0, 0, 1, 0, 1, 0));
    apply(mkv(1, 0, 0, 1, 0, -1, 0));
    for (int i = 0; i < 4; i++) apply(mkv(0, 0, 0, 1, 0, -1, 0));
    chk("rst_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/twiddle_gen.md
# twiddle_gen

Parametrised, pipelined twiddle-factor generator for the MDC FFT datapath. On `start` it latches a stage number and then emits one W_N^k = cos(2πk/N) − j·sin(2πk/N) per `advance`, sweeping the index sequence that stage's butterfly column needs. It replaces the fixed 8-entry combinational twiddle ROMs with a single block serving any power-of-two N and any coefficient width. Twiddles are stored as a quarter-wave table and unfolded by quadrant.

## Interface
- `N_POINTS`, 32: FFT size; power of two, minimum 8.
- `W_WIDTH`, 9: signed coefficient width; unity scale = 2^(W_WIDTH−2) (128 at the default).
- `STG_W`, $clog2($clog2(N_POINTS)): width of `stage`.

- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  restart the sweep at index 0 and latch `stage`.
- `stage`  in  STG_W  FFT stage s; stride = 2^s.
- `advance`  in  1  request the next twiddle.
- `inv`  in  1  conjugate output (only with TWIDDLE_IFFT_EN).
- `tw_valid`  out  1  `tw_re`/`tw_im` valid this cycle.
- `tw_re`  out  W_WIDTH  signed real part.
- `tw_im`  out  W_WIDTH  signed imaginary part.
- `tw_idx`  out  $clog2(N_POINTS)  index k of the current output.
- `tw_last`  out  1  final twiddle of the stage sweep.

## Operation
- FSM with two states, IDLE and RUN.
  - Reset enters IDLE.
  - `start` enters RUN from either state.
  - RUN is left only by `rst`.
- On `start`:
  - n ← 0.
  - s ← min(`stage`, log2(N)−2), latched.
  - `advance` in the same cycle is ignored; `start` has priority.
- In RUN, each `advance`:
  - Issues k = (n << s) mod N.
  - Then increments n.
  - n wraps to 0 after n_max = (N >> (s+1)) − 1, staying in RUN so back-to-back frames need no new `start`.
- `advance` in IDLE is ignored; no output is produced.
- Quarter-wave tables `c[r]` and `s[r]`, r = 0..N/4−1:
  - Each entry is trunc_toward_zero(2^(W_WIDTH−2) · cos or sin(2πr/N)).
  - N=32, W=9 gives c = 128,125,118,106,90,71,48,24 and s = 0,24,48,71,90,106,118,125.
- Quadrant unfold, with q = k[MSB:MSB−1] and r = k mod N/4:
  - q0 → (c[r], −s[r])
  - q1 → (−s[r], −c[r])
  - q2 → (−c[r], s[r])
  - q3 → (s[r], c[r])
- Width rule: |value| ≤ 2^(W_WIDTH−2), so negation never overflows. No saturation logic.
- `tw_last` = 1 when the issued n equals n_max.
- `tw_idx` carries k aligned with its data.

## Timing
- Two-stage pipeline; latency 2 cycles from an accepted `advance` to `tw_valid`.
  - P1 registers r, q and the last flag.
  - P2 registers the table read, sign/swap, `tw_idx` and `tw_last`.
- Throughput: one twiddle per cycle with `advance` held high.
- No gaps except those in `advance`.
- Reset values: `tw_valid`=0, `tw_re`=0, `tw_im`=0, `tw_idx`=0, `tw_last`=0, state=IDLE, n=0.
- `rst` mid-sweep clears both pipeline stages at the same edge; nothing in flight is emitted afterwards.
- `start` mid-sweep does not flush. Up to two in-flight outputs from the old sweep still emerge; the first new-sweep output follows 2 cycles after the first post-start `advance`.
- `stage` is sampled only when `start`=1.

## Configuration
- `TWIDDLE_IFFT_EN` defined:
  - `inv` is sampled with each accepted `advance` and pipelined with it.
  - When set, `tw_im` is negated, giving the conjugate twiddle for inverse FFT.
- `TWIDDLE_IFFT_EN` undefined:
  - The `inv` port still exists but is ignored.
  - The output is always the forward twiddle.

## Structure
- Package `fft_pkg`:
  - Constant function `twiddle_q(r, n, w, is_sin)` for table generation, using real math at elaboration with truncation toward zero.
  - FSM state enum.
  - Quadrant-code typedef.
- One sub-module, `twiddle_qrom`: registered dual-output quarter-wave ROM (r in, c[r]/s[r] out, one cycle), initialised from the package function.

## Test plan
- Reset, then `start` stage 0 and `advance` for 16 cycles:
  - k=0..15 in order.
  - k=1 → (125,−24).
  - k=4 → (90,−90).
  - k=8 → (0,−128).
  - k=12 → (−90,−90).
  - `tw_last` only on k=15.
  - First `tw_valid` 2 cycles after the first `advance`.
- `start` stage 1, 8 advances:
  - k=0,2,…,14.
  - k=14 → (−118,−48) with `tw_last`=1.
  - The 9th advance wraps to k=0.
- `stage`=7 with N=32: clamped to s=3; outputs k=0 → (128,0) then k=8 → (0,−128) with `tw_last`, then wrap.
- `advance` with gaps (1,0,1,1,0): `tw_valid` pattern matches the accepted advances delayed by 2; `advance` in IDLE produces nothing.
- Assert `rst` while two outputs are in flight: all outputs are 0 next cycle, and no stale valid appears.
- TWIDDLE_IFFT_EN build, `inv`=1, stage 0, k=1: output (125,24). Toggling `inv` per advance flips only the matching output's `tw_im` sign.
